// File: rtl/serial_deframer.sv
// Start-bit framed serial receiver: LSB-first word assembly into a 2-entry output FIFO.
// Define SERIAL_DEFRAMER_PARITY_EN to add an even-parity bit between data and stop.
module serial_deframer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             par_err,
    output logic             overflow,
    input  logic             ovf_clr
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef SERIAL_DEFRAMER_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} state_t;
`endif

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sr_q;
    logic             ferr_q;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       fcnt_q, fcnt_d;
    logic             valid_q;
    logic             ovf_q, ovf_d;

    logic stop_smp, par_bad, good, pop, room, push, ovf_evt;

`ifdef SERIAL_DEFRAMER_PARITY_EN
    logic par_q;
    logic perr_q;
    assign par_bad = ^{sr_q, par_q};
    assign par_err = perr_q;
`else
    assign par_bad = 1'b0;
    assign par_err = 1'b0;
`endif

    assign stop_smp = bit_en && (state_q == S_STOP);
    assign good     = stop_smp && !bit_in && !par_bad;
    assign pop      = valid_q && out_ready;
    // A full FIFO still has room when its head leaves on the same edge.
    assign room     = (fcnt_q != 2'd2) || pop;
    assign push     = good && room;
    assign ovf_evt  = good && !room;

    assign out_data  = head_q;
    assign out_valid = valid_q;
    assign frame_err = ferr_q;
    assign overflow  = ovf_q;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        fcnt_d = fcnt_q;
        case ({push, pop})
            2'b10: begin
                if (fcnt_q == 2'd0) head_d = sr_q;
                else                tail_d = sr_q;
                fcnt_d = fcnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                fcnt_d = fcnt_q - 2'd1;
            end
            2'b11: begin
                if (fcnt_q == 2'd1) begin
                    head_d = sr_q;
                end else begin
                    head_d = tail_q;
                    tail_d = sr_q;
                end
            end
            default: ;
        endcase
        ovf_d = ovf_evt ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            ferr_q  <= 1'b0;
`ifdef SERIAL_DEFRAMER_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            ferr_q <= stop_smp && bit_in;
`ifdef SERIAL_DEFRAMER_PARITY_EN
            perr_q <= stop_smp && !bit_in && par_bad;
`endif
            if (bit_en) begin
                case (state_q)
                    S_IDLE: begin
                        if (bit_in) begin
                            state_q <= S_DATA;
                            cnt_q   <= '0;
                        end
                    end
                    S_DATA: begin
                        sr_q[cnt_q] <= bit_in;
                        cnt_q       <= cnt_q + 1'b1;
                        if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SERIAL_DEFRAMER_PARITY_EN
                            state_q <= S_PAR;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end
`ifdef SERIAL_DEFRAMER_PARITY_EN
                    S_PAR: begin
                        par_q   <= bit_in;
                        state_q <= S_STOP;
                    end
`endif
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            fcnt_q  <= 2'd0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            fcnt_q  <= fcnt_d;
            valid_q <= (fcnt_d != 2'd0);
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_serial_deframer.sv
// Scoreboard bench for serial_deframer: expected words queued at drive time, popped on handshake.
module tb_serial_deframer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         bit_in;
    logic         bit_en;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         frame_err;
    logic         par_err;
    logic         overflow;
    logic         ovf_clr;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] sb[$];

    always #5 clk = ~clk;

    serial_deframer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .frame_err(frame_err), .par_err(par_err), .overflow(overflow),
        .ovf_clr(ovf_clr)
    );

    always @(negedge clk) begin
        logic [W-1:0] exp;
        if (rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got %h expected no word", out_data);
            end else begin
                exp = sb.pop_front();
                if (out_data !== exp) begin
                    errors++;
                    $display("FAIL sb_data got %h expected %h", out_data, exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t expected finish", $time);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic b);
        bit_in = b;
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
        bit_in = 1'b0;
    endtask

    task automatic gap();
        bit_en = 1'b0;
        bit_in = 1'($urandom_range(0, 1));
        tick();
        bit_in = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] w, input logic stop, input logic par, input bit gaps);
        sample(1'b1);
        if (gaps) gap();
        for (int i = 0; i < W; i++) begin
            sample(w[i]);
            if (gaps) gap();
        end
`ifdef SERIAL_DEFRAMER_PARITY_EN
        sample(par);
        if (gaps) gap();
`endif
        sample(stop);
    endtask

    task automatic test_reset();
        logic bad;
        rst = 1'b0; bit_in = 1'b0; bit_en = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        repeat (2) tick();
        checks++;
        if ({out_valid, frame_err, par_err, overflow} !== 4'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_state got v=%b fe=%b pe=%b ov=%b d=%h expected all 0",
                     out_valid, frame_err, par_err, overflow, out_data);
        end
        rst = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            sample(1'b0);
            bad = out_valid | frame_err | par_err | overflow;
            checks++;
            if (bad !== 1'b0) begin
                errors++;
                $display("FAIL idle_outputs cycle %0d got v=%b fe=%b pe=%b ov=%b expected 0",
                         i, out_valid, frame_err, par_err, overflow);
            end
        end
    endtask

    task automatic test_single();
        logic [W-1:0] w = 8'hA5;
        out_ready = 1'b1;
        sb.push_back(w);
        sample(1'b1);
        for (int i = 0; i < W; i++) sample(w[i]);
`ifdef SERIAL_DEFRAMER_PARITY_EN
        sample(^w);
`endif
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early_valid got %b expected 0", out_valid);
        end
        sample(1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== w) begin
            errors++;
            $display("FAIL single_latency got v=%b d=%h expected v=1 d=%h", out_valid, out_data, w);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain got v=%b expected 0", out_valid);
        end
    endtask

    task automatic test_bad_stop();
        out_ready = 1'b1;
        send_frame(8'h3C, 1'b1, ^8'h3C, 1'b0);
        checks++;
        if (frame_err !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bad_stop_pulse got fe=%b v=%b expected fe=1 v=0", frame_err, out_valid);
        end
        tick();
        checks++;
        if (frame_err !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bad_stop_after got fe=%b v=%b expected fe=0 v=0", frame_err, out_valid);
        end
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b0, ^8'h11, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            errors++;
            $display("FAIL bad_stop_recover got v=%b d=%h expected v=1 d=11", out_valid, out_data);
        end
        repeat (3) tick();
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        sb.push_back(8'h01);
        sb.push_back(8'h02);
        send_frame(8'h01, 1'b0, ^8'h01, 1'b0);
        send_frame(8'h02, 1'b0, ^8'h02, 1'b0);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_early got %b expected 0", overflow);
        end
        send_frame(8'h03, 1'b0, ^8'h03, 1'b0);
        checks++;
        if (overflow !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h01) begin
            errors++;
            $display("FAIL ovf_set got ov=%b v=%b d=%h expected ov=1 v=1 d=01", overflow, out_valid, out_data);
        end
        repeat (3) tick();
        checks++;
        if (out_data !== 8'h01) begin
            errors++;
            $display("FAIL stall_stable got %h expected 01", out_data);
        end
        out_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL ovf_drain got v=%b pending=%0d expected v=0 pending=0", out_valid, sb.size());
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %b expected 1", overflow);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr got %b expected 0", overflow);
        end
    endtask

    task automatic test_gaps_reset();
        logic [W-1:0] p = 8'hF0;
        out_ready = 1'b1;
        sb.push_back(8'hC3);
        send_frame(8'hC3, 1'b0, ^8'hC3, 1'b1);
        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL gaps_word pending=%0d expected 0", sb.size());
        end
        out_ready = 1'b0;
        send_frame(8'h55, 1'b0, ^8'h55, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL queued_before_rst got v=%b expected 1", out_valid);
        end
        sample(1'b1);
        for (int i = 0; i < 4; i++) sample(p[i]);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL async_rst got v=%b d=%h expected v=0 d=00", out_valid, out_data);
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_empty got v=%b expected 0", out_valid);
        end
        out_ready = 1'b1;
        sb.push_back(8'h7E);
        send_frame(8'h7E, 1'b0, ^8'h7E, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h7E) begin
            errors++;
            $display("FAIL post_rst_frame got v=%b d=%h expected v=1 d=7e", out_valid, out_data);
        end
        repeat (3) tick();
    endtask

`ifdef SERIAL_DEFRAMER_PARITY_EN
    task automatic test_parity();
        out_ready = 1'b1;
        sb.push_back(8'h0F);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0);
        checks++;
        if (par_err !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL par_ok_0f got pe=%b v=%b expected pe=0 v=1", par_err, out_valid);
        end
        repeat (2) tick();
        send_frame(8'h07, 1'b0, 1'b0, 1'b0);
        checks++;
        if (par_err !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL par_bad_07 got pe=%b v=%b expected pe=1 v=0", par_err, out_valid);
        end
        tick();
        checks++;
        if (par_err !== 1'b0) begin
            errors++;
            $display("FAIL par_pulse_len got %b expected 0", par_err);
        end
        sb.push_back(8'h07);
        send_frame(8'h07, 1'b0, 1'b1, 1'b0);
        checks++;
        if (par_err !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h07) begin
            errors++;
            $display("FAIL par_ok_07 got pe=%b v=%b d=%h expected pe=0 v=1 d=07", par_err, out_valid, out_data);
        end
        repeat (3) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_bad_stop();
        test_overflow();
        test_gaps_reset();
`ifdef SERIAL_DEFRAMER_PARITY_EN
        test_parity();
`endif
        repeat (2) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
